// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble generation, run/drain/halt FSM, saturating perf counters.
// Latency: pipeline controls are combinational in the same cycle; cpu_state and counters update on the next clk edge.
// Backpressure: none; the outputs are the stall/bubble back-pressure for the pipeline registers.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       W_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic [1:0]       cpu_state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [2:0] S_AOK    = 3'd1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic load_use, ret_pend, mispred, m_exc, w_exc, halted;

    always_comb begin
        load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != R_NONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        ret_pend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        mispred  = (E_icode == I_JXX) && !e_Cnd;
        m_exc    = (m_stat == 3'd2) || (m_stat == 3'd3) || (m_stat == 3'd4);
        w_exc    = (W_stat == 3'd2) || (W_stat == 3'd3) || (W_stat == 3'd4);
        halted   = (state_q == ST_HALTED);
    end

    // Once halted, the pipeline is frozen in place regardless of what the stages present.
    always_comb begin
        if (halted) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            D_bubble = 1'b0;
            E_bubble = 1'b0;
            M_bubble = 1'b1;
            W_stall  = 1'b1;
            set_cc   = 1'b0;
        end else begin
            F_stall  = load_use || ret_pend;
            D_stall  = load_use;
            D_bubble = mispred || (ret_pend && !load_use);
            E_bubble = mispred || load_use;
            M_bubble = m_exc || w_exc;
            W_stall  = w_exc;
            set_cc   = (E_icode == I_OPQ) && !m_exc && !w_exc;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (w_exc)      state_d = ST_HALTED;
                else if (m_exc) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_exc) state_d = ST_HALTED;
            end
            default: state_d = ST_HALTED;
        endcase
    end

    always_comb begin
        cycle_cnt_d  = cycle_cnt_q;
        retire_cnt_d = retire_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!halted) begin
            if (cycle_cnt_q != CNT_MAX)
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            if ((W_stat == S_AOK) && !W_stall && (retire_cnt_q != CNT_MAX))
                retire_cnt_d = retire_cnt_q + CNT_W'(1);
            if ((D_bubble || E_bubble) && (bubble_cnt_q != CNT_MAX))
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign cpu_state  = state_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign retire_cnt = retire_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule
